urv_rf_scrubber: RTL and testbench
==================================

Name: urv_rf_scrubber

Overview:
- Background ECC scrub controller for the register file when it is built with ECC (39-bit words: 7 check bits above 32 data bits).
- Every g_interval cycles it walks x1..x31 through a dedicated scrub read port and checks each word.
- Single-bit errors are corrected by writing the word back through the shared write port. Uncorrectable errors are flagged.
- Owns the register-file write port: core writeback always wins; scrub writes use idle cycles only.

Parameters:
- g_interval, 1024, idle cycles between scrub passes (≥2).
- g_max_wait, 15, max cycles a pending correction waits for a free write port before being abandoned.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- enable_i  in  1  scrubbing enabled; low forces return to IDLE after the current pass step
- core_we_i  in  1  core writeback strobe
- core_wa_i  in  5  core writeback address
- core_wd_i  in  39  core writeback word {ecc,data}
- rf_ra_o  out  5  scrub read address
- rf_re_o  out  1  scrub read enable (synchronous read, data valid next cycle)
- rf_rq_i  in  39  scrub read data
- rf_we_o  out  1  write enable to all register banks
- rf_wa_o  out  5  write address
- rf_wd_o  out  39  write data
- busy_o  out  1  pass in progress
- err_corr_o  out  1  one-cycle pulse: correction written
- err_uncorr_o  out  1  one-cycle pulse: uncorrectable word detected
- err_addr_o  out  5  register index of last error event (held)

Behaviour:
- Reset values: all outputs 0, state IDLE, idx=1, interval counter=0.
- Write port mux (combinational):
  - core_we_i=1: rf_we/wa/wd = core_*.
  - Otherwise: scrub write in state WRITE.
  - Core writes are never delayed.
- FSM:
  - IDLE: counter increments while enable_i=1. At g_interval-1: counter←0, idx←1, go READ.
  - READ: rf_re_o=1, rf_ra_o=idx, stale←0 → CHECK.
  - CHECK: syn = urv_ecc(rf_rq_i[31:0]) ^ rf_rq_i[38:32].
    - syn==0 or stale → NEXT.
    - syn equals exactly one column signature (data bit i: urv_ecc(1<<i); check bit j: 1<<j) → corrected word = rf_rq_i ^ (1<<bit), wait←0 → WRITE.
    - else → err_uncorr_o pulse, err_addr_o←idx → NEXT.
  - WRITE:
    - stale → NEXT, no write.
    - core_we_i=0 → rf_we_o=1, rf_wa_o=idx, rf_wd_o=corrected; err_corr_o pulse, err_addr_o←idx → NEXT.
    - else wait++; wait==g_max_wait → NEXT, no write.
  - NEXT: idx==31 → IDLE, else idx++ → READ. enable_i=0 → IDLE.
- Stale rule: core_we_i && core_wa_i==idx in READ, CHECK or WRITE sets stale. Regmem read-during-write returns old data, so the READ cycle is included. Stale forces the correction to be dropped so a fresh core value is never overwritten.
- x0 is never scrubbed.
- busy_o=1 in every state except IDLE.
- Pass latency without errors: 31×3 cycles.
- Reset mid-pass: immediate return to IDLE; no partial write issued after reset deasserts.

Optional Feature:
- URV_SCRUB_STATS_EN
- Defined: adds outputs corr_cnt_o[15:0] and uncorr_cnt_o[15:0]. These are saturating counters incremented with err_corr_o / err_uncorr_o, reset to 0.
- Undefined: ports and counters absent.

Decomposition:
- Shared package/defs: state encoding (IDLE, READ, CHECK, WRITE, NEXT), ECC word width 39, check-bit width 7, x0 index constant.
- One sub-module: urv_ecc_syndrome_dec. Takes the 39-bit word and returns {single, multi, flip_mask[38:0]}. It reuses urv_ecc for both the syndrome and the column signatures.

Test Plan:
- Clean regfile, g_interval=8 → busy_o rises after 8 idle cycles, 31 READs to addresses 1..31, no rf_we_o from scrubber, returns to IDLE.
- Flip data bit 5 of x7 → one scrub write to addr 7 with original 39-bit word restored, err_corr_o pulse, err_addr_o=7.
- Flip two data bits of x12 → err_uncorr_o pulse, err_addr_o=12, no write to x12.
- Single error in x3; core writes x3=0x1234 (valid ecc) during CHECK → no scrub write, x3 reads 0x1234.
- Single error in x9; core_we_i held high with addr 20 for 20 cycles → scrub write abandoned after 15 waits. Core writes pass through unchanged on every cycle.
- Assert rst_i during WRITE wait → all outputs 0 immediately; next pass starts at x1 after g_interval cycles.

Source files
------------

// File: rtl/urv_rf_scrubber_pkg.sv
// Shared definitions for the register-file ECC scrubber: word layout, FSM states
// and the ECC generator (32 data bits -> 7 check bits, SEC-DED).
package urv_rf_scrubber_pkg;

    localparam int c_data_w = 32;
    localparam int c_ecc_w  = 7;
    localparam int c_word_w = c_data_w + c_ecc_w;

    localparam logic [4:0] c_x0        = 5'd0;
    localparam logic [4:0] c_first_reg = c_x0 + 5'd1;
    localparam logic [4:0] c_last_reg  = 5'd31;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CHECK,
        S_WRITE,
        S_NEXT
    } scrub_state_t;

    function automatic logic [2:0] f_weight(input logic [6:0] c);
        return 3'(c[0]) + 3'(c[1]) + 3'(c[2]) + 3'(c[3]) +
               3'(c[4]) + 3'(c[5]) + 3'(c[6]);
    endfunction

    // Data bit n owns the n-th weight-3 column in ascending order; check bits own
    // the weight-1 columns, so any double error leaves an even-weight syndrome.
    function automatic logic [c_ecc_w-1:0] urv_ecc(input logic [c_data_w-1:0] d);
        logic [c_ecc_w-1:0] ecc;
        logic [c_ecc_w-1:0] col;
        int n;
        ecc = '0;
        n   = 0;
        for (int k = 1; k < 128; k++) begin
            col = 7'(k);
            if (f_weight(col) == 3'd3 && n < c_data_w) begin
                if (d[n[4:0]]) begin
                    ecc = ecc ^ col;
                end
                n++;
            end
        end
        return ecc;
    endfunction

endpackage

// File: rtl/urv_ecc_syndrome_dec.sv
// Syndrome decoder: classifies a 39-bit {ecc,data} word as clean, single-bit
// (with the bit to flip) or multi-bit.
module urv_ecc_syndrome_dec
    import urv_rf_scrubber_pkg::*;
(
    input  logic [c_word_w-1:0] i_word,
    output logic                o_single,
    output logic                o_multi,
    output logic [c_word_w-1:0] o_flip_mask
);

    logic [c_ecc_w-1:0] w_syn;

    assign w_syn = urv_ecc(i_word[c_data_w-1:0]) ^ i_word[c_word_w-1:c_data_w];

    always_comb begin
        o_flip_mask = '0;
        for (int i = 0; i < c_data_w; i++) begin
            o_flip_mask[i] = (w_syn == urv_ecc(32'(1) << i));
        end
        for (int j = 0; j < c_ecc_w; j++) begin
            o_flip_mask[c_data_w + j] = (w_syn == (7'(1) << j));
        end
    end

    assign o_single = |o_flip_mask;
    assign o_multi  = (w_syn != '0) && !o_single;

endmodule

// File: rtl/urv_rf_scrubber.sv
// Background ECC scrubber for the uRV register file; owns the shared write port.
// Optional macro URV_SCRUB_STATS_EN adds saturating correction/uncorrectable counters.
module urv_rf_scrubber
    import urv_rf_scrubber_pkg::*;
#(
    parameter int g_interval = 1024,
    parameter int g_max_wait = 15
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                enable_i,
    input  logic                core_we_i,
    input  logic [4:0]          core_wa_i,
    input  logic [c_word_w-1:0] core_wd_i,
    output logic [4:0]          rf_ra_o,
    output logic                rf_re_o,
    input  logic [c_word_w-1:0] rf_rq_i,
    output logic                rf_we_o,
    output logic [4:0]          rf_wa_o,
    output logic [c_word_w-1:0] rf_wd_o,
    output logic                busy_o,
    output logic                err_corr_o,
    output logic                err_uncorr_o,
    output logic [4:0]          err_addr_o
`ifdef URV_SCRUB_STATS_EN
    ,
    output logic [15:0]         corr_cnt_o,
    output logic [15:0]         uncorr_cnt_o
`endif
);

    localparam int c_cnt_w  = $clog2(g_interval);
    localparam int c_wait_w = $clog2(g_max_wait + 1);
    localparam logic [c_cnt_w-1:0]  c_cnt_last = c_cnt_w'(g_interval - 1);
    localparam logic [c_wait_w-1:0] c_wait_max = c_wait_w'(g_max_wait);

    scrub_state_t          r_state, w_state_nxt;
    logic [4:0]            r_idx, w_idx_nxt;
    logic [c_cnt_w-1:0]    r_cnt, w_cnt_nxt;
    logic [c_wait_w-1:0]   r_wait, w_wait_nxt;
    logic                  r_stale, w_stale_nxt;
    logic [c_word_w-1:0]   r_corr, w_corr_nxt;
    logic                  r_err_corr, w_err_corr_nxt;
    logic                  r_err_uncorr, w_err_uncorr_nxt;
    logic [4:0]            r_err_addr, w_err_addr_nxt;

    logic                  w_hit, w_stale, w_re, w_scrub_we;
    logic                  w_single, w_multi;
    logic [c_word_w-1:0]   w_flip;

    urv_ecc_syndrome_dec u_dec (
        .i_word      (rf_rq_i),
        .o_single    (w_single),
        .o_multi     (w_multi),
        .o_flip_mask (w_flip)
    );

    // A core write to the register under scrub makes the word in flight stale.
    assign w_hit   = core_we_i && (core_wa_i == r_idx);
    assign w_stale = r_stale || w_hit;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_idx        <= c_first_reg;
            r_cnt        <= '0;
            r_wait       <= '0;
            r_stale      <= 1'b0;
            r_corr       <= '0;
            r_err_corr   <= 1'b0;
            r_err_uncorr <= 1'b0;
            r_err_addr   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_cnt        <= w_cnt_nxt;
            r_wait       <= w_wait_nxt;
            r_stale      <= w_stale_nxt;
            r_corr       <= w_corr_nxt;
            r_err_corr   <= w_err_corr_nxt;
            r_err_uncorr <= w_err_uncorr_nxt;
            r_err_addr   <= w_err_addr_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_idx_nxt        = r_idx;
        w_cnt_nxt        = r_cnt;
        w_wait_nxt       = r_wait;
        w_stale_nxt      = r_stale;
        w_corr_nxt       = r_corr;
        w_err_corr_nxt   = 1'b0;
        w_err_uncorr_nxt = 1'b0;
        w_err_addr_nxt   = r_err_addr;
        w_re             = 1'b0;
        w_scrub_we       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable_i) begin
                    if (r_cnt == c_cnt_last) begin
                        w_cnt_nxt   = '0;
                        w_idx_nxt   = c_first_reg;
                        w_state_nxt = S_READ;
                    end else begin
                        w_cnt_nxt = r_cnt + c_cnt_w'(1);
                    end
                end
            end
            S_READ: begin
                w_re        = 1'b1;
                w_stale_nxt = w_hit;
                w_state_nxt = S_CHECK;
            end
            S_CHECK: begin
                w_stale_nxt = w_stale;
                if (w_stale || (!w_single && !w_multi)) begin
                    w_state_nxt = S_NEXT;
                end else if (w_single) begin
                    w_corr_nxt  = rf_rq_i ^ w_flip;
                    w_wait_nxt  = '0;
                    w_state_nxt = S_WRITE;
                end else begin
                    w_err_uncorr_nxt = 1'b1;
                    w_err_addr_nxt   = r_idx;
                    w_state_nxt      = S_NEXT;
                end
            end
            S_WRITE: begin
                w_stale_nxt = w_stale;
                if (w_stale) begin
                    w_state_nxt = S_NEXT;
                end else if (!core_we_i) begin
                    w_scrub_we     = 1'b1;
                    w_err_corr_nxt = 1'b1;
                    w_err_addr_nxt = r_idx;
                    w_state_nxt    = S_NEXT;
                end else begin
                    w_wait_nxt = r_wait + c_wait_w'(1);
                    if (w_wait_nxt == c_wait_max) begin
                        w_state_nxt = S_NEXT;
                    end
                end
            end
            S_NEXT: begin
                if (!enable_i || r_idx == c_last_reg) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_idx_nxt   = r_idx + 5'd1;
                    w_state_nxt = S_READ;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Core writeback always owns the port; the scrubber only fills idle cycles.
    always_comb begin
        rf_we_o = 1'b0;
        rf_wa_o = '0;
        rf_wd_o = '0;
        if (core_we_i) begin
            rf_we_o = 1'b1;
            rf_wa_o = core_wa_i;
            rf_wd_o = core_wd_i;
        end else if (w_scrub_we) begin
            rf_we_o = 1'b1;
            rf_wa_o = r_idx;
            rf_wd_o = r_corr;
        end
    end

    assign rf_re_o      = w_re;
    assign rf_ra_o      = w_re ? r_idx : 5'd0;
    assign busy_o       = (r_state != S_IDLE);
    assign err_corr_o   = r_err_corr;
    assign err_uncorr_o = r_err_uncorr;
    assign err_addr_o   = r_err_addr;

`ifdef URV_SCRUB_STATS_EN
    logic [15:0] r_corr_cnt, r_uncorr_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_corr_cnt   <= '0;
            r_uncorr_cnt <= '0;
        end else begin
            if (w_err_corr_nxt && r_corr_cnt != 16'hFFFF) begin
                r_corr_cnt <= r_corr_cnt + 16'd1;
            end
            if (w_err_uncorr_nxt && r_uncorr_cnt != 16'hFFFF) begin
                r_uncorr_cnt <= r_uncorr_cnt + 16'd1;
            end
        end
    end

    assign corr_cnt_o   = r_corr_cnt;
    assign uncorr_cnt_o = r_uncorr_cnt;
`endif

endmodule

// File: tb/tb_urv_rf_scrubber.sv
// Bench for urv_rf_scrubber: models the register file and checks scrub passes,
// corrections, uncorrectable flags, stale drops, write-port arbitration and reset.
module tb_urv_rf_scrubber;

    localparam int cInterval = 8;
    localparam int cMaxWait  = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        coreWe = 1'b0;
    logic [4:0]  coreWa = '0;
    logic [38:0] coreWd = '0;
    logic [4:0]  rfRa;
    logic        rfRe;
    logic [38:0] rfRq = '0;
    logic        rfWe;
    logic [4:0]  rfWa;
    logic [38:0] rfWd;
    logic        busy;
    logic        errCorr;
    logic        errUncorr;
    logic [4:0]  errAddr;
`ifdef URV_SCRUB_STATS_EN
    logic [15:0] corrCnt;
    logic [15:0] uncorrCnt;
`endif

    int testsRun = 0;
    int testsFailed = 0;

    logic [6:0]  colTab [32];
    logic [38:0] mem    [32];
    logic [38:0] golden [32];
    logic        pokeEn = 1'b0;
    logic [4:0]  pokeAddr = '0;
    logic [38:0] pokeData = '0;
    logic        monEn = 1'b0;

    logic [4:0]  readQ   [$];
    logic [43:0] scrubQ  [$];
    logic [4:0]  corrQ   [$];
    logic [4:0]  uncorrQ [$];

    urv_rf_scrubber #(
        .g_interval (cInterval),
        .g_max_wait (cMaxWait)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .enable_i     (enable),
        .core_we_i    (coreWe),
        .core_wa_i    (coreWa),
        .core_wd_i    (coreWd),
        .rf_ra_o      (rfRa),
        .rf_re_o      (rfRe),
        .rf_rq_i      (rfRq),
        .rf_we_o      (rfWe),
        .rf_wa_o      (rfWa),
        .rf_wd_o      (rfWd),
        .busy_o       (busy),
        .err_corr_o   (errCorr),
        .err_uncorr_o (errUncorr),
        .err_addr_o   (errAddr)
`ifdef URV_SCRUB_STATS_EN
        ,
        .corr_cnt_o   (corrCnt),
        .uncorr_cnt_o (uncorrCnt)
`endif
    );

    always #5 clk = ~clk;

    // Register file model: synchronous read returning the pre-write contents.
    always @(posedge clk) begin
        if (pokeEn) begin
            mem[pokeAddr] <= pokeData;
        end else if (rfWe && rfWa != 5'd0) begin
            mem[rfWa] <= rfWd;
        end
        if (rfRe) begin
            rfRq <= mem[rfRa];
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [6:0] benchEcc(input logic [31:0] d);
        logic [6:0] e;
        e = '0;
        for (int i = 0; i < 32; i++) begin
            if (d[i]) e = e ^ colTab[i];
        end
        return e;
    endfunction

    function automatic logic [38:0] mkWord(input logic [31:0] d);
        return {benchEcc(d), d};
    endfunction

    // Watches the ports every cycle: core writes must pass straight through,
    // scrub writes must carry a clean codeword and only occur during a pass.
    always @(negedge clk) begin
        if (monEn && !rst) begin
            if (coreWe) begin
                checkOutput("coreMux", {rfWe, rfWa, rfWd}, {1'b1, coreWa, coreWd});
            end else if (rfWe) begin
                scrubQ.push_back({rfWa, rfWd});
                checkOutput("scrubEcc", 64'(rfWd[38:32]), 64'(benchEcc(rfWd[31:0])));
                checkOutput("scrubWhileBusy", 64'(busy), 64'd1);
            end
            if (rfRe) begin
                readQ.push_back(rfRa);
                checkOutput("readWhileBusy", 64'(busy), 64'd1);
            end
            if (errCorr) corrQ.push_back(errAddr);
            if (errUncorr) uncorrQ.push_back(errAddr);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic we, input logic [4:0] wa, input logic [38:0] wd);
        coreWe = we;
        coreWa = wa;
        coreWd = wd;
    endtask

    task automatic poke(input logic [4:0] a, input logic [38:0] d);
        pokeEn   = 1'b1;
        pokeAddr = a;
        pokeData = d;
        tick();
        pokeEn = 1'b0;
    endtask

    task automatic clearQueues();
        readQ.delete();
        scrubQ.delete();
        corrQ.delete();
        uncorrQ.delete();
    endtask

    task automatic startPass(input string tag);
        int n;
        n = 0;
        enable = 1'b1;
        while (!busy && n < 50) begin
            tick();
            n++;
        end
        checkOutput({tag, "Latency"}, 64'(n), 64'(cInterval));
    endtask

    task automatic finishPass(output int cyc);
        cyc = 0;
        while (busy && cyc < 500) begin
            tick();
            cyc++;
        end
        checkOutput("passEnds", 64'(busy), 64'd0);
        enable = 1'b0;
    endtask

    task automatic waitRead(input logic [4:0] a);
        int n;
        n = 0;
        while (!(rfRe && rfRa == a) && n < 200) begin
            tick();
            n++;
        end
        checkOutput("readReached", 64'(rfRe && rfRa == a), 64'd1);
    endtask

    initial begin
        int cyc;
        int n;
        logic ok;
        logic [38:0] bad;

        n = 0;
        for (int v = 1; v < 128; v++) begin
            if ($countones(7'(v)) == 3 && n < 32) begin
                colTab[n] = 7'(v);
                n++;
            end
        end
        checkOutput("eccBit0", 64'(benchEcc(32'h0000_0001)), 64'h07);
        checkOutput("eccBit5", 64'(benchEcc(32'h0000_0020)), 64'h15);
        checkOutput("eccBit31", 64'(benchEcc(32'h8000_0000)), 64'h62);
        checkOutput("eccTwoBits", 64'(benchEcc(32'h0000_0003)), 64'h0c);

        applyStimulus(1'b0, 5'd0, '0);
        golden[0] = '0;
        for (int i = 1; i < 32; i++) begin
            golden[i] = mkWord(32'h9E37_79B9 * 32'(i));
            poke(5'(i), golden[i]);
        end
        tick();
        checkOutput("resetOutputs",
                    {rfRa, rfRe, rfWe, rfWa, rfWd, busy, errCorr, errUncorr, errAddr}, 64'd0);

        // Clean pass straight out of reset.
        rst   = 1'b0;
        monEn = 1'b1;
        startPass("clean");
        finishPass(cyc);
        checkOutput("cleanPassLen", 64'(cyc), 64'(31 * 3));
        checkOutput("cleanReads", 64'(readQ.size()), 64'd31);
        ok = 1'b1;
        foreach (readQ[k]) if (readQ[k] != 5'(k + 1)) ok = 1'b0;
        checkOutput("cleanReadOrder", 64'(ok), 64'd1);
        checkOutput("cleanScrubWrites", 64'(scrubQ.size()), 64'd0);
        checkOutput("cleanErrPulses", 64'(corrQ.size() + uncorrQ.size()), 64'd0);

        // Single data-bit error in x7.
        clearQueues();
        poke(5'd7, golden[7] ^ (39'd1 << 5));
        startPass("corr");
        finishPass(cyc);
        checkOutput("corrWrites", 64'(scrubQ.size()), 64'd1);
        if (scrubQ.size() > 0) checkOutput("corrWriteWord", 64'(scrubQ[0]), 64'({5'd7, golden[7]}));
        checkOutput("corrPulses", 64'(corrQ.size()), 64'd1);
        if (corrQ.size() > 0) checkOutput("corrPulseAddr", 64'(corrQ[0]), 64'd7);
        checkOutput("corrErrAddrHeld", 64'(errAddr), 64'd7);
        checkOutput("corrMemX7", 64'(mem[7]), 64'(golden[7]));
        checkOutput("corrNoUncorr", 64'(uncorrQ.size()), 64'd0);

        // Double data-bit error in x12.
        clearQueues();
        bad = golden[12] ^ (39'd1 << 3) ^ (39'd1 << 9);
        poke(5'd12, bad);
        startPass("uncorr");
        finishPass(cyc);
        checkOutput("uncorrPassLen", 64'(cyc), 64'(31 * 3));
        checkOutput("uncorrPulses", 64'(uncorrQ.size()), 64'd1);
        if (uncorrQ.size() > 0) checkOutput("uncorrPulseAddr", 64'(uncorrQ[0]), 64'd12);
        checkOutput("uncorrErrAddr", 64'(errAddr), 64'd12);
        checkOutput("uncorrNoWrite", 64'(scrubQ.size()), 64'd0);
        checkOutput("uncorrMemX12", 64'(mem[12]), 64'(bad));
        poke(5'd12, golden[12]);

        // Single error in x3, core rewrites x3 while the scrubber checks it.
        clearQueues();
        poke(5'd3, golden[3] ^ (39'd1 << 17));
        startPass("stale");
        waitRead(5'd3);
        tick();
        golden[3] = mkWord(32'h0000_1234);
        applyStimulus(1'b1, 5'd3, golden[3]);
        tick();
        applyStimulus(1'b0, 5'd0, '0);
        finishPass(cyc);
        checkOutput("staleNoWrite", 64'(scrubQ.size()), 64'd0);
        checkOutput("staleNoCorr", 64'(corrQ.size()), 64'd0);
        checkOutput("staleX3Data", 64'(mem[3][31:0]), 64'h1234);
        checkOutput("staleX3Word", 64'(mem[3]), 64'(golden[3]));

        // Single check-bit error in x9 while the core hogs the port for 20 cycles.
        clearQueues();
        bad = golden[9] ^ (39'd1 << 33);
        poke(5'd9, bad);
        startPass("starve");
        waitRead(5'd9);
        tick();
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1'b1, 5'd20, mkWord(32'hCAFE_0000 + 32'(k)));
            tick();
        end
        applyStimulus(1'b0, 5'd0, '0);
        golden[20] = mkWord(32'hCAFE_0013);
        finishPass(cyc);
        checkOutput("starveNoWrite", 64'(scrubQ.size()), 64'd0);
        checkOutput("starveNoCorr", 64'(corrQ.size()), 64'd0);
        checkOutput("starveMemX9", 64'(mem[9]), 64'(bad));
        checkOutput("starveMemX20", 64'(mem[20]), 64'(golden[20]));
        poke(5'd9, golden[9]);

        // Reset while a correction for x4 waits for the write port.
        clearQueues();
        poke(5'd4, golden[4] ^ (39'd1 << 22));
        startPass("midReset");
        waitRead(5'd4);
        tick();
        applyStimulus(1'b1, 5'd25, golden[25]);
        tick();
        tick();
        tick();
        #1;
        rst = 1'b1;
        applyStimulus(1'b0, 5'd0, '0);
        #1;
        checkOutput("midResetOutputs",
                    {rfRa, rfRe, rfWe, rfWa, rfWd, busy, errCorr, errUncorr, errAddr}, 64'd0);
        tick();
        tick();
        rst = 1'b0;
        clearQueues();
        startPass("afterReset");
        finishPass(cyc);
        checkOutput("afterResetReads", 64'(readQ.size()), 64'd31);
        if (readQ.size() > 0) checkOutput("afterResetFirstRead", 64'(readQ[0]), 64'd1);
        checkOutput("afterResetWrites", 64'(scrubQ.size()), 64'd1);
        if (scrubQ.size() > 0) checkOutput("afterResetWriteWord", 64'(scrubQ[0]), 64'({5'd4, golden[4]}));
        checkOutput("afterResetMemX4", 64'(mem[4]), 64'(golden[4]));
        checkOutput("afterResetErrAddr", 64'(errAddr), 64'd4);
        checkOutput("afterResetMemX25", 64'(mem[25]), 64'(golden[25]));
`ifdef URV_SCRUB_STATS_EN
        checkOutput("statsCorr", 64'(corrCnt), 64'd1);
        checkOutput("statsUncorr", 64'(uncorrCnt), 64'd0);
`endif

        tick();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
